// File: rtl/attopu_pkg.sv
// Shared types for the attopu memory-side blocks: requester ownership encoding
// and the default DMA lock burst limit.
package attopu_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam int unsigned LOCK_MAX_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter (bit 0 = CPU, bit 1 = DMA) with a bounded DMA lock.
// Grant is combinational; the last-owner and lock-burst counters are registered.
module rr_arb2
    import attopu_pkg::*;
#(
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       lock_i,
    output logic [1:0] gnt_o
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

    owner_e        last_q, last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          locked;
    logic          yield;

    always_comb begin
        gnt_o      = 2'b00;
        last_d     = last_q;
        lock_cnt_d = '0;
        locked     = (last_q == OWN_DMA) && lock_i && req_i[1];
        yield      = (lock_cnt_q == LOCK_LIM) && req_i[0];

        if (rst) begin
            gnt_o = 2'b00;
        end else if (locked && !yield) begin
            gnt_o = 2'b10;
        end else if (req_i == 2'b11) begin
            gnt_o = (last_q == OWN_CPU) ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end

        if (gnt_o[0]) begin
            last_d = OWN_CPU;
        end else if (gnt_o[1]) begin
            last_d = OWN_DMA;
        end

        // Counter is zero whenever the previous cycle had no DMA grant, so a
        // fresh burst starts at 1; it parks at the limit so a yield is never missed.
        if (gnt_o[1]) begin
            lock_cnt_d = (lock_cnt_q == LOCK_LIM) ? LOCK_LIM : lock_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= OWN_DMA;
            lock_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and a DMA
// master: one access per cycle, read data returned to the issuing requester.
module mem_arbiter
    import attopu_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    input  logic          dma_lock,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cnt
);

    logic [1:0]    gnt;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          tag_vld_q, tag_vld_d;
    owner_e        tag_own_q, tag_own_d;
    logic [15:0]   stall_q, stall_d;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata [2];

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  ({dma_req, cpu_req}),
        .lock_i (dma_lock),
        .gnt_o  (gnt)
    );

    assign cpu_gnt = gnt[0];
    assign dma_gnt = gnt[1];

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (gnt[0]) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (gnt[1]) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    always_comb begin
        tag_vld_d = (|gnt) && !mem_we;
        tag_own_d = gnt[1] ? OWN_DMA : (gnt[0] ? OWN_CPU : OWN_NONE);
        stall_d   = stall_q;
        if (cpu_req && !gnt[0] && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_vld_q   <= 1'b0;
            tag_own_q   <= OWN_NONE;
            stall_q     <= '0;
        end else begin
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
            stall_q     <= stall_d;
        end
    end

    // Per-requester return path; the rst mask kills a read tagged just before reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        localparam owner_e SIDE = (gi == 0) ? OWN_CPU : OWN_DMA;
        logic [DW-1:0] rdata_q;

        assign rvalid[gi] = tag_vld_q && (tag_own_q == SIDE) && !rst;
        assign rdata[gi]  = rvalid[gi] ? mem_rdata : rdata_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rvalid[gi]) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid = rvalid[0];
    assign dma_rvalid = rvalid[1];
    assign cpu_rdata  = rdata[0];
    assign dma_rdata  = rdata[1];
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written lock and
// reset sequences, random traffic against a behavioural model, and stall saturation.
module tb_mem_arbiter;

    localparam int LMAX = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata, stall_cnt;

    mem_arbiter #(.AW(16), .DW(16), .LOCK_MAX(LMAX)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dma_lock(dma_lock),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    // Second instance with a lock limit beyond the stall counter range.
    logic        s_rst, s_cpu_req, s_cpu_we, s_dma_req, s_dma_we, s_dma_lock;
    logic [15:0] s_cpu_addr, s_cpu_wdata, s_dma_addr, s_dma_wdata, s_mem_rdata;
    logic        s_cpu_gnt, s_cpu_rvalid, s_dma_gnt, s_dma_rvalid, s_mem_we;
    logic [15:0] s_cpu_rdata, s_dma_rdata, s_mem_addr, s_mem_wdata, s_stall;
    logic        sat_done = 1'b0;

    mem_arbiter #(.AW(16), .DW(16), .LOCK_MAX(70000)) u_sat (
        .clk(clk), .rst(s_rst),
        .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
        .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
        .dma_req(s_dma_req), .dma_we(s_dma_we), .dma_addr(s_dma_addr), .dma_wdata(s_dma_wdata),
        .dma_gnt(s_dma_gnt), .dma_rvalid(s_dma_rvalid), .dma_rdata(s_dma_rdata),
        .dma_lock(s_dma_lock),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
        .stall_cnt(s_stall)
    );

    // Bench memory: synchronous read, unwritten words return a fixed address pattern.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A00);
    endfunction

    logic [15:0]  mem [0:255];
    logic [255:0] mem_vld;
    always @(posedge clk) begin
        if (rst) mem_vld <= '0;
        else if (mem_we) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            mem_vld[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= mem_vld[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        creq, cwe;
        logic [15:0] caddr, cwd;
        logic        dreq, dwe;
        logic [15:0] daddr, dwd;
        logic        lock;
    } in_t;

    typedef struct {
        in_t         in;
        logic        all;
        logic        cg, dg, we;
        logic [15:0] addr, wd;
        logic        crv, drv;
        logic [15:0] crd, drd, stall;
    } row_t;

    function automatic in_t mk_in(input logic r, input logic cq, input logic cw,
                                  input logic [15:0] ca, input logic [15:0] cd,
                                  input logic dq, input logic dw,
                                  input logic [15:0] da, input logic [15:0] dd, input logic l);
        in_t v;
        v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd; v.lock = l;
        return v;
    endfunction

    function automatic row_t mk_row(input in_t v, input logic all, input logic cg, input logic dg,
                                    input logic we, input logic [15:0] addr, input logic [15:0] wd,
                                    input logic crv, input logic drv, input logic [15:0] crd,
                                    input logic [15:0] drd, input logic [15:0] stall);
        row_t r;
        r.in = v; r.all = all; r.cg = cg; r.dg = dg; r.we = we; r.addr = addr; r.wd = wd;
        r.crv = crv; r.drv = drv; r.crd = crd; r.drd = drd; r.stall = stall;
        return r;
    endfunction

    task automatic drive(input in_t v);
        @(negedge clk);
        rst = v.rst;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwd;
        dma_lock = v.lock;
        #1;
    endtask

    // Reference model state: requester-level view of ownership, bursts and returns.
    int          m_last;          // 0 = CPU went last, 1 = DMA went last
    int          m_burst;         // consecutive cycles DMA has been granted
    int          m_stall;
    bit          m_pv;
    int          m_pown;
    logic [15:0] m_pdata, m_addr, m_wd;
    logic [15:0] m_rd [2];
    logic [15:0] sh [0:255];
    bit          sh_v [0:255];

    task automatic model_reset();
        m_last = 1; m_burst = 0; m_stall = 0; m_pv = 0; m_pown = 0;
        m_pdata = '0; m_addr = '0; m_wd = '0; m_rd[0] = '0; m_rd[1] = '0;
        for (int i = 0; i < 256; i++) sh_v[i] = 0;
    endtask

    row_t  rows[$];
    in_t   idle, v;

    initial begin
        idle = mk_in(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        drive(mk_in(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0));

        //               in                                                          all cg dg we addr      wd        crv drv crd       drd       stall
        rows.push_back(mk_row(mk_in(1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,0),             1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'd0));
        rows.push_back(mk_row(mk_in(0,1,0,16'h10,16'h0,0,0,16'h0,16'h0,0),            1, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'd0));
        rows.push_back(mk_row(idle,                                                    1, 0, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'hBEEF, 16'h0000, 16'd0));
        rows.push_back(mk_row(mk_in(0,0,0,16'h0,16'h0,1,1,16'h20,16'h1234,0),         1, 0, 1, 1, 16'h0020, 16'h1234, 0, 0, 16'hBEEF, 16'h0000, 16'd0));
        rows.push_back(mk_row(idle,                                                    1, 0, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 16'd0));
        rows.push_back(mk_row(mk_in(0,1,0,16'h11,16'h0,1,0,16'h12,16'h0,0),           1, 1, 0, 0, 16'h0011, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 16'd0));
        rows.push_back(mk_row(mk_in(0,1,0,16'h13,16'h0,1,0,16'h12,16'h0,0),           1, 0, 1, 0, 16'h0012, 16'h0000, 1, 0, 16'h5A11, 16'h0000, 16'd0));
        rows.push_back(mk_row(mk_in(0,1,0,16'h13,16'h0,1,0,16'h14,16'h0,0),           1, 1, 0, 0, 16'h0013, 16'h0000, 0, 1, 16'h5A11, 16'h5A12, 16'd1));
        rows.push_back(mk_row(mk_in(0,1,0,16'h15,16'h0,1,0,16'h14,16'h0,0),           1, 0, 1, 0, 16'h0014, 16'h0000, 1, 0, 16'h5A13, 16'h5A12, 16'd1));
        rows.push_back(mk_row(mk_in(0,1,0,16'h15,16'h0,0,0,16'h0,16'h0,0),            1, 1, 0, 0, 16'h0015, 16'h0000, 0, 1, 16'h5A13, 16'h5A14, 16'd2));
        rows.push_back(mk_row(idle,                                                    1, 0, 0, 0, 16'h0015, 16'h0000, 1, 0, 16'h5A15, 16'h5A14, 16'd2));
        rows.push_back(mk_row(mk_in(0,1,0,16'h20,16'h0,0,0,16'h0,16'h0,0),            1, 1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h5A15, 16'h5A14, 16'd2));
        rows.push_back(mk_row(idle,                                                    1, 0, 0, 0, 16'h0020, 16'h0000, 1, 0, 16'h1234, 16'h5A14, 16'd2));

        foreach (rows[i]) begin
            drive(rows[i].in);
            $display("[TB] row %0d cg=%0b dg=%0b we=%0b addr=%h crv=%0b drv=%0b", i,
                     cpu_gnt, dma_gnt, mem_we, mem_addr, cpu_rvalid, dma_rvalid);
            chk($sformatf("row%0d cpu_gnt", i), cpu_gnt, rows[i].cg);
            chk($sformatf("row%0d dma_gnt", i), dma_gnt, rows[i].dg);
            chk($sformatf("row%0d mem_we", i), mem_we, rows[i].we);
            chk($sformatf("row%0d cpu_rvalid", i), cpu_rvalid, rows[i].crv);
            chk($sformatf("row%0d dma_rvalid", i), dma_rvalid, rows[i].drv);
            if (rows[i].all) begin
                chk($sformatf("row%0d mem_addr", i), mem_addr, rows[i].addr);
                chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, rows[i].crd);
                chk($sformatf("row%0d dma_rdata", i), dma_rdata, rows[i].drd);
                chk($sformatf("row%0d stall_cnt", i), stall_cnt, rows[i].stall);
                if (rows[i].we) chk($sformatf("row%0d mem_wdata", i), mem_wdata, rows[i].wd);
            end
        end

        // Lock burst: DMA wins alone, then keeps ownership until LOCK_MAX, then yields.
        drive(mk_in(1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,0));
        drive(mk_in(1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,0));
        drive(mk_in(0,0,0,16'h0,16'h0,1,0,16'h30,16'h0,1));
        $display("[TB] lock start dg=%0b", dma_gnt);
        chk("lock first dma_gnt", dma_gnt, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            drive(mk_in(0,1,0,16'h31,16'h0,1,0,16'h30 + 16'(k),16'h0,1));
            $display("[TB] lock burst %0d cg=%0b dg=%0b stall=%0d", k, cpu_gnt, dma_gnt, stall_cnt);
            chk($sformatf("lock burst%0d dma_gnt", k), dma_gnt, 1'b1);
            chk($sformatf("lock burst%0d cpu_gnt", k), cpu_gnt, 1'b0);
            chk($sformatf("lock burst%0d stall", k), stall_cnt, 16'(k - 1));
            if (k == 1) chk("lock dma_rdata", dma_rdata, 16'h5A30);
        end
        drive(mk_in(0,1,0,16'h31,16'h0,1,0,16'h34,16'h0,1));
        $display("[TB] lock yield cg=%0b dg=%0b stall=%0d", cpu_gnt, dma_gnt, stall_cnt);
        chk("lock yield cpu_gnt", cpu_gnt, 1'b1);
        chk("lock yield dma_gnt", dma_gnt, 1'b0);
        chk("lock yield stall", stall_cnt, 16'd3);
        chk("lock yield mem_addr", mem_addr, 16'h0031);
        drive(mk_in(0,1,0,16'h32,16'h0,1,0,16'h34,16'h0,1));
        chk("after yield dma_gnt", dma_gnt, 1'b1);
        drive(mk_in(0,1,0,16'h32,16'h0,0,0,16'h0,16'h0,0));
        chk("after yield cpu_gnt", cpu_gnt, 1'b1);
        chk("after yield stall", stall_cnt, 16'd4);
        drive(mk_in(0,0,0,16'h0,16'h0,1,0,16'h35,16'h0,1));
        chk("relock dma_gnt", dma_gnt, 1'b1);
        drive(mk_in(0,1,0,16'h33,16'h0,1,0,16'h36,16'h0,1));
        chk("relock hold dma_gnt", dma_gnt, 1'b1);
        drive(mk_in(0,1,0,16'h33,16'h0,1,0,16'h37,16'h0,0));
        $display("[TB] lock drop cg=%0b dg=%0b", cpu_gnt, dma_gnt);
        chk("lock drop cpu_gnt", cpu_gnt, 1'b1);

        // Reset right after a granted CPU read.
        drive(mk_in(0,1,0,16'h10,16'h0,0,0,16'h0,16'h0,0));
        chk("pre-reset cpu_gnt", cpu_gnt, 1'b1);
        drive(mk_in(1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,0));
        $display("[TB] mid reset crv=%0b cg=%0b", cpu_rvalid, cpu_gnt);
        chk("reset cycle cpu_rvalid", cpu_rvalid, 1'b0);
        chk("reset cycle cpu_gnt", cpu_gnt, 1'b0);
        drive(idle);
        chk("post-reset cpu_rvalid", cpu_rvalid, 1'b0);
        chk("post-reset cpu_rdata", cpu_rdata, 16'h0);
        chk("post-reset dma_rdata", dma_rdata, 16'h0);
        chk("post-reset stall", stall_cnt, 16'h0);
        chk("post-reset mem_addr", mem_addr, 16'h0);
        drive(mk_in(0,1,0,16'h40,16'h0,1,0,16'h41,16'h0,0));
        chk("post-reset tie cpu_gnt", cpu_gnt, 1'b1);
        chk("post-reset tie dma_gnt", dma_gnt, 1'b0);

        // Random traffic against the reference model.
        drive(mk_in(1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,0));
        model_reset();
        begin
            bit          cg_prev, dg_prev, e_c, e_d, e_we, e_crv, e_drv;
            logic [15:0] e_addr, e_wd, a;
            cg_prev = 1; dg_prev = 1;
            v = idle;
            for (int c = 0; c < 400; c++) begin
                if (cg_prev || v.rst || !v.creq) begin
                    v.creq = ($urandom_range(0, 2) != 0); v.cwe = 1'($urandom_range(0, 1));
                    v.caddr = 16'($urandom_range(0, 31)); v.cwd = 16'($urandom);
                end
                if (dg_prev || v.rst || !v.dreq) begin
                    v.dreq = ($urandom_range(0, 2) != 0); v.dwe = 1'($urandom_range(0, 1));
                    v.daddr = 16'($urandom_range(0, 31)); v.dwd = 16'($urandom);
                end
                v.lock = ($urandom_range(0, 3) != 0);
                v.rst  = ($urandom_range(0, 79) == 0);
                drive(v);

                e_c = 0; e_d = 0;
                if (!v.rst) begin
                    if (v.creq && v.dreq) begin
                        if (m_last == 1 && v.lock) e_d = (m_burst < LMAX);
                        else                       e_d = (m_last == 0);
                        e_c = !e_d;
                    end else begin
                        e_c = v.creq; e_d = v.dreq;
                    end
                end
                e_we   = e_c ? v.cwe : (e_d ? v.dwe : 1'b0);
                e_addr = e_c ? v.caddr : (e_d ? v.daddr : m_addr);
                e_wd   = e_c ? v.cwd : (e_d ? v.dwd : m_wd);
                e_crv  = !v.rst && m_pv && (m_pown == 0);
                e_drv  = !v.rst && m_pv && (m_pown == 1);

                if (e_c || e_d)
                    $display("[TB] rnd %0d %s %s addr=%h", c, e_c ? "cpu" : "dma", e_we ? "wr" : "rd", e_addr);
                chk($sformatf("rnd%0d cpu_gnt", c), cpu_gnt, e_c);
                chk($sformatf("rnd%0d dma_gnt", c), dma_gnt, e_d);
                chk($sformatf("rnd%0d mem_we", c), mem_we, e_we);
                chk($sformatf("rnd%0d cpu_rvalid", c), cpu_rvalid, e_crv);
                chk($sformatf("rnd%0d dma_rvalid", c), dma_rvalid, e_drv);
                if (!v.rst) begin
                    chk($sformatf("rnd%0d mem_addr", c), mem_addr, e_addr);
                    chk($sformatf("rnd%0d cpu_rdata", c), cpu_rdata, e_crv ? m_pdata : m_rd[0]);
                    chk($sformatf("rnd%0d dma_rdata", c), dma_rdata, e_drv ? m_pdata : m_rd[1]);
                    chk($sformatf("rnd%0d stall", c), stall_cnt, 16'(m_stall));
                    if (e_we) chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, e_wd);
                end

                if (v.rst) begin
                    model_reset();
                end else begin
                    if (v.creq && !e_c && m_stall < 65535) m_stall++;
                    m_burst = e_d ? m_burst + 1 : 0;
                    if (e_c) m_last = 0;
                    else if (e_d) m_last = 1;
                    if (e_crv) m_rd[0] = m_pdata;
                    if (e_drv) m_rd[1] = m_pdata;
                    a = e_addr;
                    m_pv   = (e_c || e_d) && !e_we;
                    m_pown = e_d ? 1 : 0;
                    m_pdata = sh_v[a[7:0]] ? sh[a[7:0]] : init_val(a);
                    if ((e_c || e_d) && e_we) begin
                        sh[a[7:0]] = e_wd; sh_v[a[7:0]] = 1;
                    end
                    m_addr = e_addr; m_wd = e_wd;
                end
                cg_prev = e_c; dg_prev = e_d;
            end
        end

        wait (sat_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Stall counter saturation on the long-lock instance.
    initial begin
        s_rst = 1; s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = 16'h0; s_cpu_wdata = 16'h0;
        s_dma_req = 1; s_dma_we = 0; s_dma_addr = 16'h50; s_dma_wdata = 16'h0; s_dma_lock = 1;
        s_mem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk) s_rst = 0;
        @(negedge clk) s_cpu_req = 1;
        repeat (1000) @(posedge clk);
        @(negedge clk); #1;
        $display("[TB] sat stall=%0d after 1000 denied cycles", s_stall);
        chk("sat stall 1000", s_stall, 16'd1000);
        chk("sat cpu_gnt denied", s_cpu_gnt, 1'b0);
        repeat (64534) @(posedge clk);
        @(negedge clk); #1;
        chk("sat stall 65534", s_stall, 16'hFFFE);
        repeat (1) @(posedge clk);
        @(negedge clk); #1;
        chk("sat stall 65535", s_stall, 16'hFFFF);
        repeat (100) @(posedge clk);
        @(negedge clk); #1;
        $display("[TB] sat stall=%h after saturation", s_stall);
        chk("sat stall hold", s_stall, 16'hFFFF);
        sat_done = 1'b1;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: run did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
